// File: rtl/segdecoder_if.sv
// Display-bus and decoded-result bundle for segdecoder.
// The errcnt signal exists only when SEGDECODER_ERRCNT_EN is defined.
interface segdecoder_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned IDX_W      = 2
);
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    clr_err;
    logic [4*NUM_DIGITS-1:0] hex_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    upd;
    logic [IDX_W-1:0]        upd_idx;
    logic                    err;
`ifdef SEGDECODER_ERRCNT_EN
    logic [7:0]              errcnt;

    modport master (output an, seg, clr_err,
                    input  hex_out, digit_valid, upd, upd_idx, err, errcnt);
    modport slave  (input  an, seg, clr_err,
                    output hex_out, digit_valid, upd, upd_idx, err, errcnt);
`else
    modport master (output an, seg, clr_err,
                    input  hex_out, digit_valid, upd, upd_idx, err);
    modport slave  (input  an, seg, clr_err,
                    output hex_out, digit_valid, upd, upd_idx, err);
`endif
endinterface

// File: rtl/segdecoder.sv
// Multiplexed active-low 7-segment bus reader: stability filter, reverse
// glyph lookup, per-digit result registers and sticky error flag.
// Optional error counter: define SEGDECODER_ERRCNT_EN.
module segdecoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned IDX_W         = 2,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic      clk,
    input  logic      rst,
    segdecoder_if.slave sif
);
    localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   r_an_q, p_an_q;
    logic [6:0]              r_seg_q, p_seg_q;
    logic [4*NUM_DIGITS-1:0] hex_q;
    logic [NUM_DIGITS-1:0]   valid_q;
    logic                    upd_q;
    logic [IDX_W-1:0]        upd_idx_q;
    logic                    err_q;

    logic                    sel_valid_c;
    logic                    changed_c;
    logic                    capture_c;
    logic [IDX_W-1:0]        idx_c;
    logic [4:0]              dec_c;
    logic                    blank_c;
    logic                    err_cap_c;

    // Reverse glyph lookup: {legal, digit}
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40: decode = 5'h10;
            7'h79: decode = 5'h11;
            7'h24: decode = 5'h12;
            7'h30: decode = 5'h13;
            7'h19: decode = 5'h14;
            7'h12: decode = 5'h15;
            7'h02: decode = 5'h16;
            7'h78: decode = 5'h17;
            7'h00: decode = 5'h18;
            7'h10: decode = 5'h19;
            7'h08: decode = 5'h1A;
            7'h03: decode = 5'h1B;
            7'h46: decode = 5'h1C;
            7'h21: decode = 5'h1D;
            7'h06: decode = 5'h1E;
            7'h0E: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    // Input stage plus one-cycle-delayed copy for change detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an_q  <= '1;
            r_seg_q <= 7'h7F;
            p_an_q  <= '1;
            p_seg_q <= 7'h7F;
        end else begin
            r_an_q  <= sif.an;
            r_seg_q <= sif.seg;
            p_an_q  <= r_an_q;
            p_seg_q <= r_seg_q;
        end
    end

    // Selected position: index of the low bit of r_an
    always_comb begin
        idx_c = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!r_an_q[i]) idx_c = IDX_W'(i);
        end
    end

    // FSM state register and stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state and capture strobe
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture_c   = 1'b0;
        sel_valid_c = $onehot(~r_an_q);
        changed_c   = ({r_an_q, r_seg_q} != {p_an_q, p_seg_q});
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel_valid_c) state_d = SETTLE;
            end
            SETTLE: begin
                if (changed_c) begin
                    cnt_d   = '0;
                    state_d = sel_valid_c ? SETTLE : IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    capture_c = 1'b1;
                    cnt_d     = '0;
                    state_d   = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (changed_c) begin
                    cnt_d   = '0;
                    state_d = sel_valid_c ? SETTLE : IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Classify the captured segment pattern
    always_comb begin
        dec_c     = decode(r_seg_q);
        blank_c   = (r_seg_q == 7'h7F);
        err_cap_c = capture_c && !dec_c[4] && !blank_c;
    end

    // Result register file, update pulse and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            hex_q     <= '0;
            valid_q   <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            upd_q <= capture_c;
            if (capture_c) upd_idx_q <= idx_c;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (capture_c && !r_an_q[i]) begin
                    valid_q[i] <= dec_c[4];
                    if (dec_c[4]) hex_q[4*i +: 4] <= dec_c[3:0];
                end
            end
            if (err_cap_c)        err_q <= 1'b1;
            else if (sif.clr_err) err_q <= 1'b0;
        end
    end

    assign sif.hex_out     = hex_q;
    assign sif.digit_valid = valid_q;
    assign sif.upd         = upd_q;
    assign sif.upd_idx     = upd_idx_q;
    assign sif.err         = err_q;

`ifdef SEGDECODER_ERRCNT_EN
    logic [7:0] errcnt_q;

    // Saturating error-capture counter; clear with simultaneous error leaves 1
    always_ff @(posedge clk) begin
        if (rst) begin
            errcnt_q <= 8'h00;
        end else if (sif.clr_err) begin
            errcnt_q <= err_cap_c ? 8'h01 : 8'h00;
        end else if (err_cap_c && (errcnt_q != 8'hFF)) begin
            errcnt_q <= errcnt_q + 8'h01;
        end
    end

    assign sif.errcnt = errcnt_q;
`endif
endmodule

// File: tb/tb_segdecoder.sv
// Self-checking bench for segdecoder: vector table plus hand sequences,
// with a scoreboard of expected capture results consumed on each upd.
module tb_segdecoder;
    localparam int unsigned ND = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned SC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    segdecoder_if #(.NUM_DIGITS(ND), .IDX_W(IW)) dif ();

    segdecoder #(.NUM_DIGITS(ND), .IDX_W(IW), .STABLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .sif (dif.slave)
    );

    typedef struct {
        logic [IW-1:0] idx;
        logic [15:0]   hex;
        logic [3:0]    valid;
        logic          err;
    } exp_t;

    typedef struct {
        logic [3:0]    an;
        logic [6:0]    seg;
        logic          push;
        logic [IW-1:0] idx;
        logic [15:0]   hex;
        logic [3:0]    valid;
        logic          err;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vt[7];
    int   errors   = 0;
    int   checks   = 0;
    int   upd_seen = 0;
    int   lat;
    int   upd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every upd must match the oldest expected capture
    always @(negedge clk) begin
        if (!rst && dif.upd === 1'b1) begin
            upd_seen++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_upd: got upd idx=%0d expected no upd", dif.upd_idx);
            end else begin
                mon_e = sbq.pop_front();
                chk("upd_idx", 32'(dif.upd_idx), 32'(mon_e.idx));
                chk("hex_out", 32'(dif.hex_out), 32'(mon_e.hex));
                chk("digit_valid", 32'(dif.digit_valid), 32'(mon_e.valid));
                chk("err", 32'(dif.err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{4'b1110, 7'h40, 1'b1, 2'd0, 16'h0000, 4'b0001, 1'b0};
        vt[1] = '{4'b1101, 7'h79, 1'b1, 2'd1, 16'h0010, 4'b0011, 1'b0};
        vt[2] = '{4'b1011, 7'h24, 1'b1, 2'd2, 16'h0210, 4'b0111, 1'b0};
        vt[3] = '{4'b0111, 7'h0E, 1'b1, 2'd3, 16'hF210, 4'b1111, 1'b0};
        vt[4] = '{4'b1011, 7'h7F, 1'b1, 2'd2, 16'hF210, 4'b1011, 1'b0};
        vt[5] = '{4'b1110, 7'h55, 1'b1, 2'd0, 16'hF210, 4'b1010, 1'b1};
        vt[6] = '{4'b1110, 7'h56, 1'b1, 2'd0, 16'hF210, 4'b1010, 1'b1};

        dif.an      = '1;
        dif.seg     = 7'h7F;
        dif.clr_err = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_hex_out", 32'(dif.hex_out), 32'h0);
        chk("rst_digit_valid", 32'(dif.digit_valid), 32'h0);
        chk("rst_upd", 32'(dif.upd), 32'h0);
        chk("rst_upd_idx", 32'(dif.upd_idx), 32'h0);
        chk("rst_err", 32'(dif.err), 32'h0);
`ifdef SEGDECODER_ERRCNT_EN
        chk("rst_errcnt", 32'(dif.errcnt), 32'h0);
`endif
        rst = 1'b0;

        // First capture and its latency
        dif.an  = 4'b1110;
        dif.seg = 7'h30;
        sbq.push_back('{2'd0, 16'h0003, 4'b0001, 1'b0});
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (dif.upd === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk("first_latency", 32'(lat), 32'd6);
        repeat (4) @(negedge clk);

        // Scan, blank and error vectors
        for (int i = 0; i < 7; i++) begin
            dif.an  = vt[i].an;
            dif.seg = vt[i].seg;
            if (vt[i].push) sbq.push_back('{vt[i].idx, vt[i].hex, vt[i].valid, vt[i].err});
            repeat (8) @(negedge clk);
        end
        chk("sb_drained_table", 32'(sbq.size()), 32'd0);
`ifdef SEGDECODER_ERRCNT_EN
        chk("errcnt_two", 32'(dif.errcnt), 32'd2);
`endif

        // clr_err on the same edge as an error capture: set wins
        dif.seg = 7'h55;
        sbq.push_back('{2'd0, 16'hF210, 4'b1010, 1'b1});
        repeat (5) @(negedge clk);
        dif.clr_err = 1'b1;
        @(negedge clk);
        dif.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_set_wins", 32'(dif.err), 32'd1);
`ifdef SEGDECODER_ERRCNT_EN
        chk("errcnt_clr_and_inc", 32'(dif.errcnt), 32'd1);
`endif

        // Isolated clr_err
        dif.clr_err = 1'b1;
        @(negedge clk);
        dif.clr_err = 1'b0;
        chk("err_cleared", 32'(dif.err), 32'd0);
`ifdef SEGDECODER_ERRCNT_EN
        chk("errcnt_cleared", 32'(dif.errcnt), 32'd0);
`endif

        // Unstable segments, then an invalid multi-select: no capture
        upd0 = upd_seen;
        for (int k = 0; k < 8; k++) begin
            dif.an  = 4'b1110;
            dif.seg = k[0] ? 7'h79 : 7'h40;
            repeat (3) @(negedge clk);
        end
        dif.an  = 4'b1100;
        dif.seg = 7'h40;
        repeat (10) @(negedge clk);
        chk("no_upd_unstable", 32'(upd_seen - upd0), 32'd0);
        chk("hold_after_unstable", 32'(dif.hex_out), 32'hF210);

        // Reset in the middle of SETTLE
        dif.an  = 4'b1101;
        dif.seg = 7'h79;
        repeat (3) @(negedge clk);
        upd0    = upd_seen;
        rst     = 1'b1;
        dif.an  = '1;
        dif.seg = 7'h7F;
        @(negedge clk);
        chk("midrst_hex_out", 32'(dif.hex_out), 32'h0);
        chk("midrst_digit_valid", 32'(dif.digit_valid), 32'h0);
        chk("midrst_upd", 32'(dif.upd), 32'h0);
        chk("midrst_upd_idx", 32'(dif.upd_idx), 32'h0);
        chk("midrst_err", 32'(dif.err), 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_upd_after_rst", 32'(upd_seen - upd0), 32'd0);
        chk("sb_drained_end", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
